mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 4: idle cycles inserted after each release before the next grant; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 65535: inactivity cycles on the granted channel before a forced release; legal range 1..65535.
REQ-003 rx_byte_clk  in  1  sole clock; all state is on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 arb_en  in  1  grant enable; 0 blocks new grants, and a frame already granted runs to completion.
REQ-006 req_chA, req_chB  in  1 each  level; the channel has a buffered frame ready to stream.
REQ-007 lp_en_chA/B, sp_en_chA/B, d2c_payload_en_chA/B  in  1 each  per-channel packet activity strobes.
REQ-008 dt_chA, dt_chB  in  6 each  data type, valid while sp_en is high.
REQ-009 gnt_chA, gnt_chB  out  1 each  registered grant; the source streams only while its grant is high.
REQ-010 mux_sel  out  1  registered datapath select; 0 selects chA, 1 selects chB.
REQ-011 busy  out  1  high in GRANT_A, GRANT_B and GUARD.
REQ-012 timeout_pulse  out  1  one-cycle pulse on a forced release.

Function
REQ-013 FSM states: IDLE, GRANT_A, GRANT_B, GUARD. State, counters and outputs are all registered.
REQ-014 IDLE, arb_en=1, exactly one req high: the next state is that channel's GRANT state.
REQ-015 IDLE, arb_en=1, both req high: the channel not granted last wins (round-robin via a last_sel register).
REQ-016 IDLE, arb_en=0 or no req high: remain in IDLE.
REQ-017 Grant latency: req sampled high in IDLE at edge n gives gnt_chX=1 and mux_sel updated at edge n+1.
REQ-018 mux_sel changes only on the IDLE->GRANT transition; it holds its value through GRANT, GUARD and IDLE.
REQ-019 At most one of gnt_chA/gnt_chB is high in any cycle; both are low in IDLE and GUARD.
REQ-020 Normal release: in GRANT_X, sp_en_chX=1 with dt_chX=6'h01 (frame end) -> GUARD next cycle; gnt_chX falls on the same edge.
REQ-021 Activity and events on the non-granted channel are ignored.
REQ-022 While granted, deassertion of req_chX is ignored; release occurs only by REQ-020 or REQ-024.
REQ-023 Inactivity counter (16 bit):
- cleared on entry to GRANT_X;
- cleared on any cycle with lp_en_chX, sp_en_chX or d2c_payload_en_chX high;
- otherwise increments, saturating at TIMEOUT.
REQ-024 Forced release: counter reaches TIMEOUT in GRANT_X -> GUARD next cycle, with timeout_pulse=1 for that one cycle.
REQ-025 A frame end and the timeout condition in the same cycle: frame end wins and no timeout_pulse is generated.
REQ-026 GUARD lasts exactly GUARD_CYCLES cycles, counted by an 8-bit counter loaded on entry, then IDLE. Requests are not sampled during GUARD.
REQ-027 last_sel updates to the granted channel on each IDLE->GRANT transition.
REQ-028 arb_en falling during GRANT or GUARD has no effect until the FSM returns to IDLE.
REQ-029 A frame end on the granted channel in the first grant cycle is honoured (REQ-020).

Reset
REQ-030 reset_n low asynchronously forces all of the following, regardless of the current state (including mid-frame):
- state=IDLE;
- gnt_chA=0, gnt_chB=0;
- mux_sel=0;
- busy=0, timeout_pulse=0;
- both counters=0;
- last_sel=1, so chA wins the first contention.
REQ-031 After reset_n rises, the first grant follows REQ-017 timing.

Verification
REQ-032 Reset, then req_chA=req_chB=1 at cycle 0 -> gnt_chA=1, mux_sel=0 at cycle 1; chA frame end (sp_en_chA, dt=6'h01) at cycle 10 -> gnt_chA=0 at cycle 11; with GUARD_CYCLES=4, gnt_chB=1 and mux_sel=1 at cycle 16.
REQ-033 chA granted, no chA activity for TIMEOUT=8 cycles -> timeout_pulse high for exactly 1 cycle, gnt_chA low on the same edge, FSM enters GUARD.
REQ-034 Frame end and timeout in the same cycle -> release occurs, timeout_pulse stays 0.
REQ-035 chB granted; inject sp_en_chA with dt=6'h01 and then drop req_chB -> gnt_chB stays 1 and mux_sel stays 1 until a chB frame end.
REQ-036 reset_n pulsed low mid-frame in GRANT_B -> outputs clear immediately without waiting for a clock; after release with both req high, chA is granted first.
REQ-037 arb_en=0 with req_chA=1 for 20 cycles -> no grant; arb_en=1 -> gnt_chA=1 one cycle later.

Source files
------------

// File: rtl/mux_arbiter_if.sv
// Handshake and activity bundle between two frame sources and the arbiter.
// The arbiter uses the slave modport; the sources (or a bench) use master.
interface mux_arbiter_if;
    logic       arb_en;
    logic       req_chA;
    logic       req_chB;
    logic       lp_en_chA;
    logic       lp_en_chB;
    logic       sp_en_chA;
    logic       sp_en_chB;
    logic       d2c_payload_en_chA;
    logic       d2c_payload_en_chB;
    logic [5:0] dt_chA;
    logic [5:0] dt_chB;
    logic       gnt_chA;
    logic       gnt_chB;
    logic       mux_sel;
    logic       busy;
    logic       timeout_pulse;

    modport slave (
        input  arb_en, req_chA, req_chB, lp_en_chA, lp_en_chB, sp_en_chA, sp_en_chB,
               d2c_payload_en_chA, d2c_payload_en_chB, dt_chA, dt_chB,
        output gnt_chA, gnt_chB, mux_sel, busy, timeout_pulse
    );

    modport master (
        output arb_en, req_chA, req_chB, lp_en_chA, lp_en_chB, sp_en_chA, sp_en_chB,
               d2c_payload_en_chA, d2c_payload_en_chB, dt_chA, dt_chB,
        input  gnt_chA, gnt_chB, mux_sel, busy, timeout_pulse
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-channel frame arbiter: round-robin grant, frame-end or inactivity release,
// then a fixed guard gap before the next grant.
module mux_arbiter #(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic          rx_byte_clk,
    input  logic          reset_n,
    mux_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StGrantA, StGrantB, StGuard} stateE;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
    localparam logic [7:0]  GuardLoad  = 8'(GUARD_CYCLES - 1);

    stateE       stateQ, stateD;
    logic [15:0] inactCntQ, inactCntD;
    logic [7:0]  guardCntQ, guardCntD;
    logic        lastSelQ, lastSelD;
    logic        muxSelQ, muxSelD;
    logic        pulseD;
    logic        gntAQ, gntBQ, busyQ, pulseQ;

    logic        onB;
    logic        activity;
    logic        frameEnd;
    logic        pickB;

    // Only the granted channel's strobes matter; the other channel is ignored.
    assign onB      = (stateQ == StGrantB);
    assign activity = onB ? (bus.lp_en_chB | bus.sp_en_chB | bus.d2c_payload_en_chB)
                          : (bus.lp_en_chA | bus.sp_en_chA | bus.d2c_payload_en_chA);
    assign frameEnd = onB ? (bus.sp_en_chB && (bus.dt_chB == 6'h01))
                          : (bus.sp_en_chA && (bus.dt_chA == 6'h01));
    assign pickB    = bus.req_chB && (!bus.req_chA || !lastSelQ);

    always_comb begin
        stateD    = stateQ;
        inactCntD = inactCntQ;
        guardCntD = guardCntQ;
        lastSelD  = lastSelQ;
        muxSelD   = muxSelQ;
        pulseD    = 1'b0;
        unique case (stateQ)
            StIdle: begin
                inactCntD = 16'd0;
                if (bus.arb_en && (bus.req_chA || bus.req_chB)) begin
                    stateD   = pickB ? StGrantB : StGrantA;
                    muxSelD  = pickB;
                    lastSelD = pickB;
                end
            end
            StGrantA, StGrantB: begin
                if (frameEnd || (inactCntQ == TimeoutVal)) begin
                    // Frame end takes priority, so no pulse when both coincide.
                    stateD    = StGuard;
                    pulseD    = !frameEnd;
                    guardCntD = GuardLoad;
                    inactCntD = 16'd0;
                end else if (activity) begin
                    inactCntD = 16'd0;
                end else if (inactCntQ != TimeoutVal) begin
                    inactCntD = inactCntQ + 16'd1;
                end
            end
            StGuard: begin
                if (guardCntQ == 8'd0) begin
                    stateD = StIdle;
                end else begin
                    guardCntD = guardCntQ - 8'd1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge rx_byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ    <= StIdle;
            inactCntQ <= 16'd0;
            guardCntQ <= 8'd0;
            lastSelQ  <= 1'b1;
            muxSelQ   <= 1'b0;
            gntAQ     <= 1'b0;
            gntBQ     <= 1'b0;
            busyQ     <= 1'b0;
            pulseQ    <= 1'b0;
        end else begin
            stateQ    <= stateD;
            inactCntQ <= inactCntD;
            guardCntQ <= guardCntD;
            lastSelQ  <= lastSelD;
            muxSelQ   <= muxSelD;
            gntAQ     <= (stateD == StGrantA);
            gntBQ     <= (stateD == StGrantB);
            busyQ     <= (stateD != StIdle);
            pulseQ    <= pulseD;
        end
    end

    assign bus.gnt_chA       = gntAQ;
    assign bus.gnt_chB       = gntBQ;
    assign bus.mux_sel       = muxSelQ;
    assign bus.busy          = busyQ;
    assign bus.timeout_pulse = pulseQ;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a channel-ownership model.
module tb_mux_arbiter;

    localparam int GuardCycles = 4;
    localparam int Timeout     = 8;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    mux_arbiter_if bus ();

    mux_arbiter #(
        .GUARD_CYCLES(GuardCycles),
        .TIMEOUT     (Timeout)
    ) dut (
        .rx_byte_clk(clk),
        .reset_n    (rstN),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: who owns the link (0 none, 1 chA, 2 chB), remaining guard cycles,
    // quiet-cycle count of the owner, last winner, datapath select, pulse.
    int mOwner, mGuardLeft, mQuiet, mLast;
    bit mSel, mPulse;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOwner     = 0;
        mGuardLeft = 0;
        mQuiet     = 0;
        mLast      = 2;
        mSel       = 1'b0;
        mPulse     = 1'b0;
    endtask

    task automatic modelStep();
        bit act, fe;
        mPulse = 1'b0;
        if (mOwner != 0) begin
            if (mOwner == 1) begin
                act = bus.lp_en_chA | bus.sp_en_chA | bus.d2c_payload_en_chA;
                fe  = bus.sp_en_chA && (bus.dt_chA == 6'h01);
            end else begin
                act = bus.lp_en_chB | bus.sp_en_chB | bus.d2c_payload_en_chB;
                fe  = bus.sp_en_chB && (bus.dt_chB == 6'h01);
            end
            if (fe || mQuiet == Timeout) begin
                mPulse     = !fe;
                mOwner     = 0;
                mGuardLeft = GuardCycles;
                mQuiet     = 0;
            end else begin
                mQuiet = act ? 0 : ((mQuiet + 1 > Timeout) ? Timeout : mQuiet + 1);
            end
        end else if (mGuardLeft > 0) begin
            mGuardLeft--;
        end else if (bus.arb_en && (bus.req_chA || bus.req_chB)) begin
            if (bus.req_chA && bus.req_chB) mOwner = (mLast == 1) ? 2 : 1;
            else                            mOwner = bus.req_chA ? 1 : 2;
            mLast  = mOwner;
            mSel   = (mOwner == 2);
            mQuiet = 0;
        end
    endtask

    task automatic compareModel();
        chk("gnt_chA",       int'(bus.gnt_chA),       int'(mOwner == 1));
        chk("gnt_chB",       int'(bus.gnt_chB),       int'(mOwner == 2));
        chk("mux_sel",       int'(bus.mux_sel),       int'(mSel));
        chk("busy",          int'(bus.busy),          int'(mOwner != 0 || mGuardLeft > 0));
        chk("timeout_pulse", int'(bus.timeout_pulse), int'(mPulse));
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        compareModel();
    endtask

    task automatic clearStrobes();
        bus.lp_en_chA          = 1'b0;
        bus.lp_en_chB          = 1'b0;
        bus.sp_en_chA          = 1'b0;
        bus.sp_en_chB          = 1'b0;
        bus.d2c_payload_en_chA = 1'b0;
        bus.d2c_payload_en_chB = 1'b0;
        bus.dt_chA             = 6'h00;
        bus.dt_chB             = 6'h00;
    endtask

    // Pulse reset low between clock edges and check outputs clear at once.
    task automatic asyncReset();
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        chk("rst_gnt_chA", int'(bus.gnt_chA), 0);
        chk("rst_gnt_chB", int'(bus.gnt_chB), 0);
        chk("rst_mux_sel", int'(bus.mux_sel), 0);
        chk("rst_busy",    int'(bus.busy),    0);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        int actPct;
        clearStrobes();
        bus.arb_en  = 1'b1;
        bus.req_chA = 1'b0;
        bus.req_chB = 1'b0;
        modelReset();
        #12;
        chk("reset_gnt_chA", int'(bus.gnt_chA),       0);
        chk("reset_gnt_chB", int'(bus.gnt_chB),       0);
        chk("reset_mux_sel", int'(bus.mux_sel),       0);
        chk("reset_busy",    int'(bus.busy),          0);
        chk("reset_pulse",   int'(bus.timeout_pulse), 0);
        @(negedge clk);
        rstN = 1'b1;

        // Contention after reset: chA first, chB after frame end plus guard.
        bus.req_chA = 1'b1;
        bus.req_chB = 1'b1;
        tick();
        chk("c1_gnt_chA", int'(bus.gnt_chA), 1);
        chk("c1_mux_sel", int'(bus.mux_sel), 0);
        bus.lp_en_chA = 1'b1;
        repeat (9) tick();
        bus.lp_en_chA = 1'b0;
        bus.sp_en_chA = 1'b1;
        bus.dt_chA    = 6'h01;
        tick();
        chk("c11_gnt_chA", int'(bus.gnt_chA), 0);
        clearStrobes();
        repeat (4) tick();
        chk("c15_gnt_chB", int'(bus.gnt_chB), 0);
        tick();
        chk("c16_gnt_chB", int'(bus.gnt_chB), 1);
        chk("c16_mux_sel", int'(bus.mux_sel), 1);
        bus.req_chA   = 1'b0;
        bus.req_chB   = 1'b0;
        bus.sp_en_chB = 1'b1;
        bus.dt_chB    = 6'h01;
        tick();
        clearStrobes();
        repeat (GuardCycles) tick();
        chk("idle_after_b", int'(bus.busy), 0);

        // Inactivity timeout on chA.
        bus.req_chA = 1'b1;
        tick();
        bus.req_chA = 1'b0;
        for (int i = 0; i < Timeout; i++) begin
            tick();
            chk("to_hold_gnt", int'(bus.gnt_chA), 1);
            chk("to_no_pulse", int'(bus.timeout_pulse), 0);
        end
        tick();
        chk("to_pulse",   int'(bus.timeout_pulse), 1);
        chk("to_gnt_low", int'(bus.gnt_chA),       0);
        chk("to_guard",   int'(bus.busy),          1);
        tick();
        chk("to_pulse_1cyc", int'(bus.timeout_pulse), 0);
        repeat (GuardCycles - 1) tick();

        // Frame end coinciding with the timeout condition.
        bus.req_chA = 1'b1;
        tick();
        bus.req_chA = 1'b0;
        repeat (Timeout) tick();
        bus.sp_en_chA = 1'b1;
        bus.dt_chA    = 6'h01;
        tick();
        chk("fe_to_gnt",   int'(bus.gnt_chA),       0);
        chk("fe_to_pulse", int'(bus.timeout_pulse), 0);
        clearStrobes();
        repeat (GuardCycles) tick();

        // chB holds through foreign frame end and its own req dropping.
        bus.req_chB = 1'b1;
        tick();
        chk("b_gnt", int'(bus.gnt_chB), 1);
        bus.sp_en_chA = 1'b1;
        bus.dt_chA    = 6'h01;
        tick();
        bus.sp_en_chA = 1'b0;
        bus.req_chB   = 1'b0;
        bus.lp_en_chB = 1'b1;
        repeat (4) begin
            tick();
            chk("b_hold_gnt", int'(bus.gnt_chB), 1);
            chk("b_hold_sel", int'(bus.mux_sel), 1);
        end
        clearStrobes();
        bus.sp_en_chB = 1'b1;
        bus.dt_chB    = 6'h01;
        tick();
        chk("b_release", int'(bus.gnt_chB), 0);
        chk("b_sel_held", int'(bus.mux_sel), 1);
        clearStrobes();
        repeat (GuardCycles) tick();

        // Asynchronous reset mid-frame, then chA wins contention.
        bus.req_chB = 1'b1;
        tick();
        bus.req_chB = 1'b0;
        tick();
        asyncReset();
        bus.req_chA = 1'b1;
        bus.req_chB = 1'b1;
        tick();
        chk("post_rst_gnt_chA", int'(bus.gnt_chA), 1);
        bus.req_chA   = 1'b0;
        bus.req_chB   = 1'b0;
        bus.sp_en_chA = 1'b1;
        bus.dt_chA    = 6'h01;
        tick();
        clearStrobes();
        repeat (GuardCycles) tick();

        // arb_en low blocks grants.
        bus.arb_en  = 1'b0;
        bus.req_chA = 1'b1;
        repeat (20) begin
            tick();
            chk("blocked_gnt", int'(bus.gnt_chA), 0);
        end
        bus.arb_en = 1'b1;
        tick();
        chk("enabled_gnt", int'(bus.gnt_chA), 1);
        bus.req_chA   = 1'b0;
        bus.sp_en_chA = 1'b1;
        bus.dt_chA    = 6'h01;
        tick();
        clearStrobes();
        repeat (GuardCycles) tick();

        // Randomized traffic, alternating busy and quiet activity phases.
        for (int c = 0; c < 3000; c++) begin
            actPct                 = ((c / 250) % 2 == 1) ? 40 : 5;
            bus.arb_en             = ($urandom_range(0, 9) != 0);
            bus.req_chA            = $urandom_range(0, 1) == 1;
            bus.req_chB            = $urandom_range(0, 1) == 1;
            bus.lp_en_chA          = $urandom_range(0, 99) < actPct;
            bus.lp_en_chB          = $urandom_range(0, 99) < actPct;
            bus.d2c_payload_en_chA = $urandom_range(0, 99) < actPct;
            bus.d2c_payload_en_chB = $urandom_range(0, 99) < actPct;
            bus.sp_en_chA          = $urandom_range(0, 99) < actPct;
            bus.sp_en_chB          = $urandom_range(0, 99) < actPct;
            bus.dt_chA             = ($urandom_range(0, 2) == 0) ? 6'h01 : 6'($urandom);
            bus.dt_chB             = ($urandom_range(0, 2) == 0) ? 6'h01 : 6'($urandom);
            tick();
            if ($urandom_range(0, 499) == 0) asyncReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
